// File: rtl/rf_pkg.sv
// Shared register-file definitions: default widths, special register
// indices and the write-port bundle used by the write-back arbiter.
package rf_pkg;

    localparam int RF_W = 8;
    localparam int RF_D = 4;

    // Never written through the arbiter; the entry is drained silently.
    localparam logic [RF_D-1:0] RF_PROT_REG = {{(RF_D-1){1'b1}}, 1'b0};
    // Reads as zero in reg_file; written normally by the arbiter.
    localparam logic [RF_D-1:0] RF_ZERO_REG = {RF_D{1'b1}};

    // Default-width write-port bundle: destination plus data.
    typedef struct packed {
        logic [RF_D-1:0] addr;
        logic [RF_W-1:0] data;
    } rf_wr_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: pure combinational priority rotation. The search
// starts one past 'last' (mod N) and the first requesting index wins.
module rr_arbiter #(
    parameter int N  = 3,
    parameter int LW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [LW-1:0] last,
    output logic [N-1:0]  grant
);

    // Walk the N indices starting at last+1 and grant the first request.
    always_comb begin
        int   idx;
        logic found;
        grant = '0;
        found = 1'b0;
        idx   = 0;
        for (int k = 1; k <= N; k++) begin
            idx = (int'(last) + k) % N;
            if (!found && req[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Write-back arbiter for the register file's single write port.
// N producers each own a one-entry buffer; one buffered write is granted
// per cycle in round-robin order. The protected register is drained
// without asserting RegWrite.
// Optional: define RF_ARB_STATS_EN to add saturating write/stall counters
// (stat_writes, stat_stall_cycles) and a stat_clear input.
//
// Handshake: a request transfers on a posedge where req_valid[i] and
// req_ready[i] are both high; req_ready[i] is high while buffer i is empty
// or is being drained this cycle, and a producer seeing ready low keeps
// its request and values unchanged.
module rf_wb_arbiter
    import rf_pkg::*;
#(
    parameter int W = RF_W,
    parameter int D = RF_D,
    parameter int N = 3
) (
    input  logic           CLK,
    input  logic           Reset,
    input  logic [N-1:0]   req_valid,
    input  logic [N*D-1:0] req_addr,
    input  logic [N*W-1:0] req_data,
    output logic [N-1:0]   req_ready,
    output logic           RegWrite,
    output logic [D-1:0]   writeReg,
    output logic [W-1:0]   writeValue,
    output logic [N-1:0]   grant
`ifdef RF_ARB_STATS_EN
    ,
    input  logic           stat_clear,
    output logic [15:0]    stat_writes,
    output logic [15:0]    stat_stall_cycles
`endif
);

    localparam int LW = $clog2(N);
    localparam logic [D-1:0] PROT_REG = {{(D-1){1'b1}}, 1'b0};

    // Same shape as rf_wr_t, sized by this instance's W/D.
    typedef struct packed {
        logic [D-1:0] addr;
        logic [W-1:0] data;
    } wr_t;

    logic [N-1:0]  full;
    wr_t           buf_q [N];
    logic [LW-1:0] last;
    logic [LW-1:0] grant_idx;
    logic [N-1:0]  accept;
    wr_t           win;

    rr_arbiter #(.N(N), .LW(LW)) u_rr (
        .req   (full),
        .last  (last),
        .grant (grant)
    );

    assign req_ready = ~full | grant;
    assign accept    = req_valid & req_ready;

    // Select the granted entry and encode its index; zero when idle.
    always_comb begin
        win       = '0;
        grant_idx = '0;
        for (int i = 0; i < N; i++) begin
            if (grant[i]) begin
                win       = buf_q[i];
                grant_idx = LW'(i);
            end
        end
    end

    assign writeReg   = win.addr;
    assign writeValue = win.data;
    assign RegWrite   = (|grant) && (win.addr != PROT_REG);

    // Buffer fill/drain and round-robin pointer update.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            full <= '0;
            last <= LW'(N - 1);
            for (int i = 0; i < N; i++) begin
                buf_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                if (accept[i]) begin
                    full[i]       <= 1'b1;
                    buf_q[i].addr <= req_addr[i*D +: D];
                    buf_q[i].data <= req_data[i*W +: W];
                end else if (grant[i]) begin
                    full[i] <= 1'b0;
                end
            end
            if (|grant) begin
                last <= grant_idx;
            end
        end
    end

`ifdef RF_ARB_STATS_EN
    logic stall;
    assign stall = |(req_valid & ~req_ready);

    // Saturating event counters; clear wins over a coincident increment.
    always_ff @(posedge CLK) begin
        if (Reset || stat_clear) begin
            stat_writes       <= '0;
            stat_stall_cycles <= '0;
        end else begin
            if (RegWrite && stat_writes != 16'hFFFF) begin
                stat_writes <= stat_writes + 16'd1;
            end
            if (stall && stat_stall_cycles != 16'hFFFF) begin
                stat_stall_cycles <= stat_stall_cycles + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Bench for rf_wb_arbiter: directed vectors, expected writes queued when
// the stimulus is issued, a monitor popping them whenever a grant shows.
module tb_rf_wb_arbiter;

    localparam int W  = 8;
    localparam int D  = 4;
    localparam int N  = 3;
    localparam int EW = N + 1 + D + W;

    logic           CLK;
    logic           Reset;
    logic [N-1:0]   req_valid;
    logic [N*D-1:0] req_addr;
    logic [N*W-1:0] req_data;
    logic [N-1:0]   req_ready;
    logic           RegWrite;
    logic [D-1:0]   writeReg;
    logic [W-1:0]   writeValue;
    logic [N-1:0]   grant;
`ifdef RF_ARB_STATS_EN
    logic           stat_clear;
    logic [15:0]    stat_writes;
    logic [15:0]    stat_stall_cycles;
`endif

    logic [EW-1:0] exp_q[$];
    int checks;
    int failures;

    rf_wb_arbiter #(.W(W), .D(D), .N(N)) dut (
        .CLK        (CLK),
        .Reset      (Reset),
        .req_valid  (req_valid),
        .req_addr   (req_addr),
        .req_data   (req_data),
        .req_ready  (req_ready),
        .RegWrite   (RegWrite),
        .writeReg   (writeReg),
        .writeValue (writeValue),
        .grant      (grant)
`ifdef RF_ARB_STATS_EN
        ,
        .stat_clear        (stat_clear),
        .stat_writes       (stat_writes),
        .stat_stall_cycles (stat_stall_cycles)
`endif
    );

    // clock / reset
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // driver tasks: inputs change 1 time unit after the rising edge
    task automatic tick(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic set_req(input int i, input logic v, input logic [D-1:0] a, input logic [W-1:0] d);
        req_valid[i]       = v;
        req_addr[i*D +: D] = a;
        req_data[i*W +: W] = d;
    endtask

    task automatic push_exp(input logic [N-1:0] g, input logic rw, input logic [D-1:0] a, input logic [W-1:0] d);
        exp_q.push_back({g, rw, a, d});
    endtask

    task automatic do_reset();
        Reset     = 1'b1;
        req_valid = '0;
        tick(1);
        Reset = 1'b0;
    endtask

    initial begin
        logic [EW-1:0] exp_v;
        checks    = 0;
        failures  = 0;
        Reset     = 1'b1;
        req_valid = '0;
        req_addr  = '0;
        req_data  = '0;
`ifdef RF_ARB_STATS_EN
        stat_clear = 1'b0;
`endif

        // scoreboard monitor: sample on the falling edge
        fork
            forever begin
                @(negedge CLK);
                if (!Reset) begin
                    if (grant != '0) begin
                        checks++;
                        if (exp_q.size() == 0) begin
                            failures++;
                            $display("FAIL unexpected_grant: got grant=%b rw=%b reg=%h val=%h, required no grant",
                                     grant, RegWrite, writeReg, writeValue);
                        end else begin
                            exp_v = exp_q.pop_front();
                            if ({grant, RegWrite, writeReg, writeValue} !== exp_v) begin
                                failures++;
                                $display("FAIL write: got grant=%b rw=%b reg=%h val=%h, required grant=%b rw=%b reg=%h val=%h",
                                         grant, RegWrite, writeReg, writeValue,
                                         exp_v[EW-1 -: N], exp_v[D+W], exp_v[W +: D], exp_v[W-1:0]);
                            end
                        end
                    end else begin
                        checks++;
                        if ({RegWrite, writeReg, writeValue} !== '0) begin
                            failures++;
                            $display("FAIL idle_outputs: got rw=%b reg=%h val=%h, required all 0",
                                     RegWrite, writeReg, writeValue);
                        end
                    end
                end
            end
        join_none

        tick(2);
        Reset = 1'b0;

        // reset state
        checks++;
        if ({grant, RegWrite, writeReg, writeValue, req_ready} !== {3'b000, 1'b0, 4'h0, 8'h00, 3'b111}) begin
            failures++;
            $display("FAIL reset_state: got grant=%b rw=%b reg=%h val=%h ready=%b, required 000 0 0 00 111",
                     grant, RegWrite, writeReg, writeValue, req_ready);
        end

        // single write
        set_req(0, 1'b1, 4'd3, 8'hA5);
        checks++;
        if (req_ready[0] !== 1'b1) begin
            failures++;
            $display("FAIL single_ready: got %b, required 1", req_ready[0]);
        end
        push_exp(3'b001, 1'b1, 4'd3, 8'hA5);
        tick(1);
        req_valid = '0;
        tick(2);

        // contention, then refill: requester 0 first after reset
        do_reset();
        set_req(0, 1'b1, 4'd1, 8'h11);
        set_req(1, 1'b1, 4'd2, 8'h22);
        set_req(2, 1'b1, 4'd3, 8'h33);
        push_exp(3'b001, 1'b1, 4'd1, 8'h11);
        push_exp(3'b010, 1'b1, 4'd2, 8'h22);
        push_exp(3'b100, 1'b1, 4'd3, 8'h33);
        tick(1);
        req_valid = '0;
        checks++;
        if (req_ready !== 3'b001) begin
            failures++;
            $display("FAIL all_full_ready: got %b, required 001", req_ready);
        end
        tick(3);
        set_req(0, 1'b1, 4'd4, 8'h44);
        set_req(1, 1'b1, 4'd5, 8'h55);
        set_req(2, 1'b1, 4'd6, 8'h66);
        push_exp(3'b001, 1'b1, 4'd4, 8'h44);
        push_exp(3'b010, 1'b1, 4'd5, 8'h55);
        push_exp(3'b100, 1'b1, 4'd6, 8'h66);
        tick(1);
        req_valid = '0;
        tick(3);

        // back-to-back streaming on requester 1
        for (int k = 0; k < 10; k++) begin
            set_req(1, 1'b1, 4'd5, 8'(k));
            push_exp(3'b010, 1'b1, 4'd5, 8'(k));
            checks++;
            if (req_ready[1] !== 1'b1) begin
                failures++;
                $display("FAIL stream_ready: beat %0d got %b, required 1", k, req_ready[1]);
            end
            tick(1);
        end
        req_valid = '0;
        tick(2);

        // protected register: granted and drained, no write strobe
        set_req(2, 1'b1, 4'd14, 8'hFF);
        push_exp(3'b100, 1'b0, 4'd14, 8'hFF);
        tick(1);
        req_valid = '0;
        tick(1);
        checks++;
        if ({grant, req_ready[2]} !== {3'b000, 1'b1}) begin
            failures++;
            $display("FAIL prot_drain: got grant=%b ready2=%b, required 000 1", grant, req_ready[2]);
        end

        // reset mid-operation discards all buffers and the reset-cycle request
        set_req(0, 1'b1, 4'd7, 8'h77);
        set_req(1, 1'b1, 4'd8, 8'h88);
        set_req(2, 1'b1, 4'd9, 8'h99);
        tick(1);
        Reset     = 1'b1;
        req_valid = '0;
        set_req(0, 1'b1, 4'd10, 8'hBB);
        tick(1);
        Reset     = 1'b0;
        req_valid = '0;
        checks++;
        if ({grant, RegWrite, req_ready} !== {3'b000, 1'b0, 3'b111}) begin
            failures++;
            $display("FAIL reset_mid: got grant=%b rw=%b ready=%b, required 000 0 111", grant, RegWrite, req_ready);
        end
        tick(2);
        set_req(0, 1'b1, 4'd1, 8'hC1);
        set_req(1, 1'b1, 4'd2, 8'hC2);
        set_req(2, 1'b1, 4'd3, 8'hC3);
        push_exp(3'b001, 1'b1, 4'd1, 8'hC1);
        push_exp(3'b010, 1'b1, 4'd2, 8'hC2);
        push_exp(3'b100, 1'b1, 4'd3, 8'hC3);
        tick(1);
        req_valid = '0;
        tick(3);

        // refill-while-draining with stalls: 4 writes, 2 stall cycles
        do_reset();
        set_req(0, 1'b1, 4'd1, 8'h11);
        set_req(1, 1'b1, 4'd2, 8'h22);
        set_req(2, 1'b1, 4'd3, 8'h33);
        push_exp(3'b001, 1'b1, 4'd1,  8'h11);
        push_exp(3'b010, 1'b1, 4'd2,  8'h22);
        push_exp(3'b100, 1'b1, 4'd3,  8'h33);
        push_exp(3'b010, 1'b0, 4'd14, 8'hEE);
        push_exp(3'b100, 1'b1, 4'd6,  8'h66);
        tick(1);
        req_valid[0] = 1'b0;
        set_req(1, 1'b1, 4'd14, 8'hEE);
        set_req(2, 1'b1, 4'd6,  8'h66);
        tick(2);
        req_valid[1] = 1'b0;
        tick(1);
        req_valid = '0;
        tick(3);
`ifdef RF_ARB_STATS_EN
        checks++;
        if ({stat_writes, stat_stall_cycles} !== {16'd4, 16'd2}) begin
            failures++;
            $display("FAIL stats_count: got writes=%0d stalls=%0d, required 4 2", stat_writes, stat_stall_cycles);
        end
        stat_clear = 1'b1;
        tick(1);
        stat_clear = 1'b0;
        checks++;
        if ({stat_writes, stat_stall_cycles} !== 32'd0) begin
            failures++;
            $display("FAIL stats_clear: got writes=%0d stalls=%0d, required 0 0", stat_writes, stat_stall_cycles);
        end
`endif

        // every expected write must have been observed
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain_queue: got %0d pending expected writes, required 0", exp_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
